// File: rtl/pm_cpu_pkg.sv
// Shared S1C88 core types: fetch FSM states and decoder immediate-size encoding.
package pm_cpu_pkg;

   typedef enum logic [2:0] {
      FETCH_OP,
      FETCH_EXT,
      IMM_LO,
      IMM_HI,
      DONE
   } fetch_state_t;

   localparam logic IMM_SIZE_8  = 1'b0;
   localparam logic IMM_SIZE_16 = 1'b1;

endpackage

// File: rtl/pm_instr_fetch.sv
// S1C88 fetch: assembles opcode/ext/imm bytes from the byte bus into one valid/ready instruction;
// 1-byte insn valid 2 cycles after first bus_req; holds output until out_ready. IFETCH_PREFETCH_EN adds a 1-byte opcode prefetch.
module pm_instr_fetch
   import pm_cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 24,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              bus_req,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_ack,
   input  logic [7:0]        bus_rdata,
   output logic [7:0]        dec_opcode,
   output logic [7:0]        dec_opext,
   input  logic              need_opext,
   input  logic              need_imm,
   input  logic              imm_size,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_opcode,
   output logic [7:0]        out_opext,
   output logic [15:0]       out_imm,
   output logic [ADDR_W-1:0] out_pc
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   fetch_state_t      state_q, state_d;
   logic              cap_q, cap_d;
   logic              discard_q, discard_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              bus_req_q, bus_req_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [7:0]        opcode_q, opcode_d;
   logic [7:0]        opext_q, opext_d;
   logic [15:0]       imm_q, imm_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic              out_valid_q, out_valid_d;
`ifdef IFETCH_PREFETCH_EN
   logic              buf_valid_q, buf_valid_d;
   logic [7:0]        buf_dat_q, buf_dat_d;
   logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
`endif

   logic xfer;
   assign xfer = bus_req_q && bus_ack;

   always_comb begin
      state_d     = state_q;
      cap_d       = cap_q;
      discard_d   = discard_q;
      pc_d        = pc_q;
      bus_req_d   = bus_req_q;
      bus_addr_d  = bus_addr_q;
      opcode_d    = opcode_q;
      opext_d     = opext_q;
      imm_d       = imm_q;
      out_pc_d    = out_pc_q;
      out_valid_d = out_valid_q;
`ifdef IFETCH_PREFETCH_EN
      buf_valid_d = buf_valid_q;
      buf_dat_d   = buf_dat_q;
      buf_pc_d    = buf_pc_q;
`endif

      if (redirect_valid) begin
         pc_d        = redirect_pc;
         state_d     = FETCH_OP;
         cap_d       = 1'b0;
         out_valid_d = 1'b0;
`ifdef IFETCH_PREFETCH_EN
         buf_valid_d = 1'b0;
`endif
         // An unanswered request cannot be withdrawn: keep it and drop its byte later.
         if (bus_req_q && !bus_ack) begin
            discard_d = 1'b1;
         end else begin
            discard_d  = 1'b0;
            bus_req_d  = 1'b1;
            bus_addr_d = redirect_pc;
         end
      end else if (discard_q) begin
         if (xfer) begin
            discard_d  = 1'b0;
            bus_req_d  = 1'b1;
            bus_addr_d = pc_q;
         end
      end else begin
         case (state_q)
            FETCH_OP: begin
               if (xfer) begin
                  opcode_d  = bus_rdata;
                  out_pc_d  = bus_addr_q;
                  opext_d   = 8'h00;
                  imm_d     = 16'h0000;
                  pc_d      = pc_q + ONE;
                  bus_req_d = 1'b0;
                  cap_d     = 1'b1;
               end else if (cap_q) begin
                  // Decoder now sees the registered opcode.
                  cap_d = 1'b0;
                  if (need_opext) begin
                     state_d    = FETCH_EXT;
                     bus_req_d  = 1'b1;
                     bus_addr_d = pc_q;
                  end else if (need_imm) begin
                     state_d    = IMM_LO;
                     bus_req_d  = 1'b1;
                     bus_addr_d = pc_q;
                  end else begin
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                  end
               end else if (!bus_req_q) begin
                  bus_req_d  = 1'b1;
                  bus_addr_d = pc_q;
               end
            end
            FETCH_EXT: begin
               if (xfer) begin
                  opext_d   = bus_rdata;
                  pc_d      = pc_q + ONE;
                  bus_req_d = 1'b0;
                  cap_d     = 1'b1;
               end else if (cap_q) begin
                  cap_d = 1'b0;
                  if (need_imm) begin
                     state_d    = IMM_LO;
                     bus_req_d  = 1'b1;
                     bus_addr_d = pc_q;
                  end else begin
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                  end
               end
            end
            IMM_LO: begin
               if (xfer) begin
                  imm_d[7:0] = bus_rdata;
                  pc_d       = pc_q + ONE;
                  if (imm_size == IMM_SIZE_16) begin
                     state_d    = IMM_HI;
                     bus_addr_d = pc_q + ONE;
                  end else begin
                     state_d     = DONE;
                     bus_req_d   = 1'b0;
                     out_valid_d = 1'b1;
                  end
               end
            end
            IMM_HI: begin
               if (xfer) begin
                  imm_d[15:8] = bus_rdata;
                  pc_d        = pc_q + ONE;
                  state_d     = DONE;
                  bus_req_d   = 1'b0;
                  out_valid_d = 1'b1;
               end
            end
            DONE: begin
`ifdef IFETCH_PREFETCH_EN
               if (xfer) begin
                  pc_d      = pc_q + ONE;
                  bus_req_d = 1'b0;
                  if (out_ready) begin
                     out_valid_d = 1'b0;
                     state_d     = FETCH_OP;
                     cap_d       = 1'b1;
                     opcode_d    = bus_rdata;
                     out_pc_d    = bus_addr_q;
                     opext_d     = 8'h00;
                     imm_d       = 16'h0000;
                  end else begin
                     buf_valid_d = 1'b1;
                     buf_dat_d   = bus_rdata;
                     buf_pc_d    = bus_addr_q;
                  end
               end else if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = FETCH_OP;
                  if (buf_valid_q) begin
                     buf_valid_d = 1'b0;
                     cap_d       = 1'b1;
                     opcode_d    = buf_dat_q;
                     out_pc_d    = buf_pc_q;
                     opext_d     = 8'h00;
                     imm_d       = 16'h0000;
                  end else if (!bus_req_q) begin
                     bus_req_d  = 1'b1;
                     bus_addr_d = pc_q;
                  end
               end else if (!bus_req_q && !buf_valid_q) begin
                  bus_req_d  = 1'b1;
                  bus_addr_d = pc_q;
               end
`else
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = FETCH_OP;
                  bus_req_d   = 1'b1;
                  bus_addr_d  = pc_q;
               end
`endif
            end
            default: state_d = FETCH_OP;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= FETCH_OP;
         cap_q       <= 1'b0;
         discard_q   <= 1'b0;
         pc_q        <= RESET_PC;
         bus_req_q   <= 1'b0;
         bus_addr_q  <= RESET_PC;
         opcode_q    <= 8'h00;
         opext_q     <= 8'h00;
         imm_q       <= 16'h0000;
         out_pc_q    <= '0;
         out_valid_q <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
         buf_valid_q <= 1'b0;
         buf_dat_q   <= 8'h00;
         buf_pc_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cap_q       <= cap_d;
         discard_q   <= discard_d;
         pc_q        <= pc_d;
         bus_req_q   <= bus_req_d;
         bus_addr_q  <= bus_addr_d;
         opcode_q    <= opcode_d;
         opext_q     <= opext_d;
         imm_q       <= imm_d;
         out_pc_q    <= out_pc_d;
         out_valid_q <= out_valid_d;
`ifdef IFETCH_PREFETCH_EN
         buf_valid_q <= buf_valid_d;
         buf_dat_q   <= buf_dat_d;
         buf_pc_q    <= buf_pc_d;
`endif
      end
   end

   assign bus_req    = bus_req_q;
   assign bus_addr   = bus_addr_q;
   assign dec_opcode = opcode_q;
   assign dec_opext  = opext_q;
   assign out_valid  = out_valid_q;
   assign out_opcode = opcode_q;
   assign out_opext  = opext_q;
   assign out_imm    = imm_q;
   assign out_pc     = out_pc_q;

endmodule
